amo_sequencer: RTL and testbench
================================

// Module: amo_sequencer
// PURPOSE
//  Multi-cycle controller for RV32A: LR.W, SC.W and AMO*.W (e_atomic_funct5 codes).
//  Takes one atomic op from the execute stage and sequences a read-modify-write on the data-memory port.
//  Holds the single LR reservation and returns the rd value.
//  Sits between execute (ATOMIC opcode decode) and the LSU memory port.
// PARAMETERS
//  XLEN    32  data width; ALU ops wrap mod 2^XLEN
//  ADDR_W  32  byte-address width
// PORTS
//  clk           in   1       clock; single clock domain
//  rst_n         in   1       reset, asynchronous, active-low
//  req_valid_i   in   1       atomic request valid
//  req_ready_o   out  1       sequencer idle, can accept a request
//  req_funct5_i  in   5       e_atomic_funct5 operation
//  req_addr_i    in   ADDR_W  byte address (rs1)
//  req_rs2_i     in   XLEN    rs2 operand / SC store data
//  resp_valid_o  out  1       one-cycle response pulse
//  resp_data_o   out  XLEN    rd value (old mem value; SC: 0 = ok, 1 = fail)
//  resp_err_o    out  1       misaligned address or illegal funct5
//  mem_req_o     out  1       memory request, held until granted
//  mem_we_o      out  1       1 = write, 0 = read
//  mem_addr_o    out  ADDR_W  word address, [1:0] = 0
//  mem_wdata_o   out  XLEN    write data
//  mem_gnt_i     in   1       request accepted this cycle
//  mem_rvalid_i  in   1       read data valid; at least 1 cycle after read grant
//  mem_rdata_i   in   XLEN    read data
//  snoop_we_i    in   1       store by another agent
//  snoop_addr_i  in   ADDR_W  address of that store
// BEHAVIOUR
//  States and transitions
//   - States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP. req_ready_o = (state==IDLE).
//   - Accept (cycle T): req_valid_i && IDLE. funct5/addr/rs2 latched.
//     - addr[1:0]!=0 or unlisted funct5 -> RESP, resp_err_o=1, resp_data_o=0, no memory access.
//     - LR -> RD_REQ.
//     - AMO* -> RD_REQ.
//     - SC, success condition: reservation valid, addr[ADDR_W-1:2] matches, no matching snoop in cycle T.
//       Success -> WR_REQ; otherwise -> RESP with resp_data_o=1 and no memory access.
//       SC clears the reservation in both cases.
//   - RD_REQ: mem_req_o=1, mem_we_o=0. On gnt -> RD_WAIT.
//   - RD_WAIT: on rvalid, capture old value.
//     - LR: set reservation {valid, word addr} -> RESP.
//     - AMO: new = op(old, rs2) registered -> WR_REQ.
//   - WR_REQ: mem_req_o=1, mem_we_o=1, mem_wdata_o = new (AMO) or rs2 (SC). On gnt -> RESP.
//   - RESP: resp_valid_o=1 for exactly one cycle, then IDLE. No response backpressure.
//  Handshake and latency
//   - mem_req_o/we/addr/wdata stay stable until gnt.
//   - Minimum latency T->resp_valid: AMO 4, LR 3, SC ok 2, SC fail/err 1 (zero-wait memory).
//  Datapath
//   - AMO ops: SWAP=rs2; ADD wraps; XOR/AND/OR bitwise.
//   - MIN/MAX compare signed; MINU/MAXU compare unsigned.
//   - resp_data_o: old value (LR/AMO), 0/1 (SC), 0 (err).
//  Reservation
//   - Cleared by: snoop_we_i with matching word address (any state), SC, an AMO write to the same word, reset.
//   - LR to another address overwrites it.
//  Reset
//   - All outputs 0 except req_ready_o=1. State IDLE, reservation invalid.
//   - rst_n low mid-operation aborts: mem_req_o drops immediately, no response, reservation lost.
//   - A late mem_rvalid_i after reset is ignored in IDLE.
// TESTING
//  1. AMOADD addr 0x100, mem=0x7FFFFFFF, rs2=1, gnt same cycle
//     -> write 0x80000000, resp_data=0x7FFFFFFF at T+4.
//  2. mem=0xFFFFFFFF, rs2=1: AMOMIN -> writes 0xFFFFFFFF; AMOMINU -> writes 0x00000001.
//  3. LR 0x200 (resp=mem value at T+3), SC 0x200 rs2=0xDEAD -> write 0xDEAD, resp 0.
//     Second SC -> resp 1 at T+1, no mem_req_o.
//  4. LR 0x200, then snoop_we_i addr 0x202 -> SC 0x200 fails (1).
//     Repeat with the snoop in the SC accept cycle -> fail.
//  5. gnt withheld 3 cycles -> mem_req/addr/wdata stable.
//     addr 0x102 -> resp_err=1 at T+1; funct5=5'b11111 -> resp_err=1; no memory access in either case.
//  6. rst_n low in RD_WAIT -> outputs at reset values, no resp, ready=1.
//     Following SC 0x200 -> resp 1.

Source files
------------

// File: rtl/amo_sequencer_if.sv
// Bus bundle for the atomic sequencer: request/response channel from the
// execute stage, data-memory request port, and the snoop input that reports
// stores by other agents.
//   slave  : view used by amo_sequencer (consumes requests, drives memory)
//   master : view used by the environment (issues requests, models memory)
interface amo_sequencer_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [4:0]        req_funct5_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [XLEN-1:0]   req_rs2_i;
    logic              resp_valid_o;
    logic [XLEN-1:0]   resp_data_o;
    logic              resp_err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              snoop_we_i;
    logic [ADDR_W-1:0] snoop_addr_i;

    modport slave (
        input  req_valid_i, req_funct5_i, req_addr_i, req_rs2_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  snoop_we_i, snoop_addr_i
    );

    modport master (
        output req_valid_i, req_funct5_i, req_addr_i, req_rs2_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output snoop_we_i, snoop_addr_i
    );
endinterface

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: accepts one LR.W / SC.W / AMO*.W from execute and
// runs the read-modify-write on the data-memory port, holding the single LR
// reservation and returning the rd value as a one-cycle response pulse.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    amo_sequencer_if.slave: request/response, memory port, snoop
module amo_sequencer #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    amo_sequencer_if.slave bus
);
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

    state_t            state_reg, state_next;
    logic [4:0]        funct5_reg, funct5_next;
    logic [ADDR_W-3:0] word_reg, word_next;
    logic [XLEN-1:0]   rs2_reg, rs2_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;
    logic [XLEN-1:0]   resp_data_reg, resp_data_next;
    logic              resp_err_reg, resp_err_next;
    logic              resv_valid_reg, resv_valid_next;
    logic [ADDR_W-3:0] resv_word_reg, resv_word_next;

    logic              resv_set, resv_clear;
    logic              legal_f5, sc_ok;
    logic [XLEN-1:0]   alu_result;
    logic [ADDR_W-3:0] req_word, snoop_word;
    logic [3:0]        unused_bits;

    assign req_word    = bus.req_addr_i[ADDR_W-1:2];
    assign snoop_word  = bus.snoop_addr_i[ADDR_W-1:2];
    assign unused_bits = {bus.snoop_addr_i[1:0], 2'b00};

    always_comb begin
        legal_f5 = 1'b0;
        case (bus.req_funct5_i)
            F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: legal_f5 = 1'b1;
            default:                      legal_f5 = 1'b0;
        endcase
    end

    // A store by another agent to the reserved word in the accept cycle
    // kills the SC even though the reservation register has not yet cleared.
    assign sc_ok = resv_valid_reg && (resv_word_reg == req_word) &&
                   !(bus.snoop_we_i && (snoop_word == req_word));

    always_comb begin
        alu_result = bus.mem_rdata_i;
        case (funct5_reg)
            F_SWAP:  alu_result = rs2_reg;
            F_ADD:   alu_result = bus.mem_rdata_i + rs2_reg;
            F_XOR:   alu_result = bus.mem_rdata_i ^ rs2_reg;
            F_AND:   alu_result = bus.mem_rdata_i & rs2_reg;
            F_OR:    alu_result = bus.mem_rdata_i | rs2_reg;
            F_MIN:   alu_result = ($signed(bus.mem_rdata_i) < $signed(rs2_reg)) ? bus.mem_rdata_i : rs2_reg;
            F_MAX:   alu_result = ($signed(bus.mem_rdata_i) > $signed(rs2_reg)) ? bus.mem_rdata_i : rs2_reg;
            F_MINU:  alu_result = (bus.mem_rdata_i < rs2_reg) ? bus.mem_rdata_i : rs2_reg;
            F_MAXU:  alu_result = (bus.mem_rdata_i > rs2_reg) ? bus.mem_rdata_i : rs2_reg;
            default: alu_result = bus.mem_rdata_i;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        funct5_next     = funct5_reg;
        word_next       = word_reg;
        rs2_next        = rs2_reg;
        wdata_next      = wdata_reg;
        resp_data_next  = resp_data_reg;
        resp_err_next   = resp_err_reg;
        resv_set        = 1'b0;
        resv_clear      = 1'b0;
        resv_valid_next = resv_valid_reg;
        resv_word_next  = resv_word_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid_i) begin
                    funct5_next    = bus.req_funct5_i;
                    word_next      = req_word;
                    rs2_next       = bus.req_rs2_i;
                    resp_err_next  = 1'b0;
                    resp_data_next = '0;
                    if ((bus.req_addr_i[1:0] != 2'b00) || !legal_f5) begin
                        resp_err_next = 1'b1;
                        state_next    = RESP;
                    end else if (bus.req_funct5_i == F_SC) begin
                        resv_clear = 1'b1;
                        if (sc_ok) begin
                            wdata_next = bus.req_rs2_i;
                            state_next = WR_REQ;
                        end else begin
                            resp_data_next = {{(XLEN-1){1'b0}}, 1'b1};
                            state_next     = RESP;
                        end
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (bus.mem_gnt_i) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    resp_data_next = bus.mem_rdata_i;
                    if (funct5_reg == F_LR) begin
                        resv_set   = 1'b1;
                        state_next = RESP;
                    end else begin
                        wdata_next = alu_result;
                        state_next = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (bus.mem_gnt_i) begin
                    // Our own AMO store to the reserved word breaks the LR/SC pair.
                    if ((funct5_reg != F_SC) && (word_reg == resv_word_reg)) begin
                        resv_clear = 1'b1;
                    end
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Set first, then let clears override, so a snoop hitting the word
        // being reserved in the same cycle leaves the reservation invalid.
        if (resv_set) begin
            resv_valid_next = 1'b1;
            resv_word_next  = word_reg;
        end
        if (bus.snoop_we_i && (snoop_word == resv_word_next)) begin
            resv_valid_next = 1'b0;
        end
        if (resv_clear) begin
            resv_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            funct5_reg     <= '0;
            word_reg       <= '0;
            rs2_reg        <= '0;
            wdata_reg      <= '0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            resv_valid_reg <= 1'b0;
            resv_word_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            funct5_reg     <= funct5_next;
            word_reg       <= word_next;
            rs2_reg        <= rs2_next;
            wdata_reg      <= wdata_next;
            resp_data_reg  <= resp_data_next;
            resp_err_reg   <= resp_err_next;
            resv_valid_reg <= resv_valid_next;
            resv_word_reg  <= resv_word_next;
        end
    end

    // Outputs decode straight from the state register so an asynchronous
    // reset drops the memory request in the same instant.
    assign bus.req_ready_o  = (state_reg == IDLE);
    assign bus.resp_valid_o = (state_reg == RESP);
    assign bus.resp_data_o  = (state_reg == RESP) ? resp_data_reg : '0;
    assign bus.resp_err_o   = (state_reg == RESP) && resp_err_reg;
    assign bus.mem_req_o    = (state_reg == RD_REQ) || (state_reg == WR_REQ);
    assign bus.mem_we_o     = (state_reg == WR_REQ);
    assign bus.mem_addr_o   = bus.mem_req_o ? {word_reg, 2'b00} : '0;
    assign bus.mem_wdata_o  = (state_reg == WR_REQ) ? wdata_reg : '0;
endmodule

// File: tb/tb_amo_sequencer.sv
module tb_amo_sequencer;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    amo_sequencer_if #(.XLEN(32), .ADDR_W(32)) bus ();

    amo_sequencer #(.XLEN(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request at posedge+1 and plays the memory: grants after
    // gwait cycles, returns rdval one cycle after a read grant.
    task automatic do_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [31:0] rdval, input int gwait,
                         input bit snp, input int exp_lat, input bit exp_rd, input bit exp_wr,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                         input bit exp_err);
        int          cyc = 0;
        int          hold = 0;
        int          lat = 0;
        bit          got = 1'b0;
        bit          saw_rd = 1'b0;
        bit          saw_wr = 1'b0;
        bit          rv_pend = 1'b0;
        logic [31:0] wd = '0;
        logic [31:0] cap_addr = '0;
        logic [31:0] cap_wdata = '0;
        logic        cap_we = 1'b0;
        logic [31:0] rdata_o = '0;
        logic        err_o = 1'b0;
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};

        chk({tag, " ready"}, {31'b0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_funct5_i = f;
        bus.req_addr_i   = a;
        bus.req_rs2_i    = rs2;
        if (snp) begin
            bus.snoop_we_i   = 1'b1;
            bus.snoop_addr_i = a + 32'd2;
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.snoop_we_i  = 1'b0;
        cyc = 1;
        while (!got && cyc <= 40) begin
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = rv_pend;
            bus.mem_rdata_i  = rv_pend ? rdval : 32'h0;
            rv_pend = 1'b0;
            if (bus.resp_valid_o) begin
                got     = 1'b1;
                lat     = cyc;
                rdata_o = bus.resp_data_o;
                err_o   = bus.resp_err_o;
            end else if (bus.mem_req_o) begin
                if (hold == 0) begin
                    cap_addr  = bus.mem_addr_o;
                    cap_wdata = bus.mem_wdata_o;
                    cap_we    = bus.mem_we_o;
                    chk({tag, " mem_addr"}, bus.mem_addr_o, exp_addr);
                end else begin
                    chk({tag, " hold addr"},  bus.mem_addr_o, cap_addr);
                    chk({tag, " hold wdata"}, bus.mem_wdata_o, cap_wdata);
                    chk({tag, " hold we"},    {31'b0, bus.mem_we_o}, {31'b0, cap_we});
                end
                if (hold >= gwait) begin
                    bus.mem_gnt_i = 1'b1;
                    if (bus.mem_we_o) begin
                        saw_wr = 1'b1;
                        wd     = bus.mem_wdata_o;
                    end else begin
                        saw_rd  = 1'b1;
                        rv_pend = 1'b1;
                    end
                    hold = 0;
                end else begin
                    hold++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;

        chk({tag, " resp seen"}, {31'b0, got}, 32'd1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " read"}, {31'b0, saw_rd}, {31'b0, exp_rd});
        chk({tag, " write"}, {31'b0, saw_wr}, {31'b0, exp_wr});
        if (exp_wr) chk({tag, " wdata"}, wd, exp_wdata);
        chk({tag, " resp_data"}, rdata_o, exp_data);
        chk({tag, " resp_err"}, {31'b0, err_o}, {31'b0, exp_err});
        $display("txn %s lat=%0d rd=%0d wr=%0d wdata=%h data=%h err=%0d",
                 tag, lat, saw_rd, saw_wr, wd, rdata_o, err_o);
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_funct5_i = 5'b0;
        bus.req_addr_i   = 32'h0;
        bus.req_rs2_i    = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        bus.snoop_we_i   = 1'b0;
        bus.snoop_addr_i = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst ready",      {31'b0, bus.req_ready_o},  32'd1);
        chk("rst resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
        chk("rst resp_data",  bus.resp_data_o,           32'd0);
        chk("rst resp_err",   {31'b0, bus.resp_err_o},   32'd0);
        chk("rst mem_req",    {31'b0, bus.mem_req_o},    32'd0);
        chk("rst mem_we",     {31'b0, bus.mem_we_o},     32'd0);
        chk("rst mem_addr",   bus.mem_addr_o,            32'd0);
        chk("rst mem_wdata",  bus.mem_wdata_o,           32'd0);
        $display("txn reset checked");
        rst_n = 1'b1;
        @(posedge clk); #1;

        //     tag        funct5  addr        rs2           rdval         gw snp lat rd wr wdata         data          err
        do_op("amoadd",  F_ADD,  32'h100, 32'h00000001, 32'h7FFFFFFF, 0, 0, 4, 1, 1, 32'h80000000, 32'h7FFFFFFF, 0);
        do_op("amomin",  F_MIN,  32'h100, 32'h00000001, 32'hFFFFFFFF, 0, 0, 4, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("amominu", F_MINU, 32'h100, 32'h00000001, 32'hFFFFFFFF, 0, 0, 4, 1, 1, 32'h00000001, 32'hFFFFFFFF, 0);
        do_op("amomax",  F_MAX,  32'h104, 32'h00000001, 32'hFFFFFFFF, 0, 0, 4, 1, 1, 32'h00000001, 32'hFFFFFFFF, 0);
        do_op("amomaxu", F_MAXU, 32'h104, 32'h00000001, 32'hFFFFFFFF, 0, 0, 4, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op("amoxor",  F_XOR,  32'h108, 32'hFF00FF00, 32'hF0F0F0F0, 0, 0, 4, 1, 1, 32'h0FF00FF0, 32'hF0F0F0F0, 0);
        do_op("amoor",   F_OR,   32'h108, 32'h0000000F, 32'h12345670, 0, 0, 4, 1, 1, 32'h1234567F, 32'h12345670, 0);
        do_op("amoswap", F_SWAP, 32'h10C, 32'hCAFEBABE, 32'h12345678, 0, 0, 4, 1, 1, 32'hCAFEBABE, 32'h12345678, 0);

        // LR/SC pair, then a second SC with the reservation consumed
        do_op("lr",      F_LR,   32'h200, 32'h0,        32'h0000ABCD, 0, 0, 3, 1, 0, 32'h0,        32'h0000ABCD, 0);
        do_op("sc ok",   F_SC,   32'h200, 32'h0000DEAD, 32'h0,        0, 0, 2, 0, 1, 32'h0000DEAD, 32'h0,        0);
        do_op("sc again",F_SC,   32'h200, 32'h0000BEEF, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h1,        0);

        // snoop to the same word while idle kills the reservation
        do_op("lr2",     F_LR,   32'h200, 32'h0,        32'h00001111, 0, 0, 3, 1, 0, 32'h0,        32'h00001111, 0);
        bus.snoop_we_i   = 1'b1;
        bus.snoop_addr_i = 32'h202;
        @(posedge clk); #1;
        bus.snoop_we_i   = 1'b0;
        do_op("sc snoop",F_SC,   32'h200, 32'h0000DEAD, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h1,        0);

        // snoop in the SC accept cycle
        do_op("lr3",     F_LR,   32'h200, 32'h0,        32'h00002222, 0, 0, 3, 1, 0, 32'h0,        32'h00002222, 0);
        do_op("sc snp@T",F_SC,   32'h200, 32'h0000DEAD, 32'h0,        0, 1, 1, 0, 0, 32'h0,        32'h1,        0);

        // AMO store to the reserved word, and an LR elsewhere, both break the pair
        do_op("lr4",     F_LR,   32'h200, 32'h0,        32'h00000005, 0, 0, 3, 1, 0, 32'h0,        32'h00000005, 0);
        do_op("amo same",F_ADD,  32'h200, 32'h00000003, 32'h00000005, 0, 0, 4, 1, 1, 32'h00000008, 32'h00000005, 0);
        do_op("sc amo",  F_SC,   32'h200, 32'h0000DEAD, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h1,        0);
        do_op("lr5",     F_LR,   32'h200, 32'h0,        32'h00000006, 0, 0, 3, 1, 0, 32'h0,        32'h00000006, 0);
        do_op("lr other",F_LR,   32'h300, 32'h0,        32'h00000007, 0, 0, 3, 1, 0, 32'h0,        32'h00000007, 0);
        do_op("sc moved",F_SC,   32'h200, 32'h0000DEAD, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h1,        0);

        // grant withheld 3 cycles on both the read and the write
        do_op("amoand gw3", F_AND, 32'h110, 32'h0F0F0F0F, 32'hFFFF0000, 3, 0, 10, 1, 1, 32'h0F0F0000, 32'hFFFF0000, 0);

        // errors: misaligned address and illegal funct5
        do_op("misalign", F_ADD,    32'h102, 32'h1, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1);
        do_op("bad f5",   5'b11111, 32'h100, 32'h1, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 1);

        // reset during RD_WAIT aborts the op and drops the reservation
        do_op("lr6",     F_LR,   32'h200, 32'h0,        32'h00000009, 0, 0, 3, 1, 0, 32'h0,        32'h00000009, 0);
        bus.req_valid_i  = 1'b1;
        bus.req_funct5_i = F_LR;
        bus.req_addr_i   = 32'h200;
        @(posedge clk); #1;
        bus.req_valid_i  = 1'b0;
        chk("abort rd_req", {31'b0, bus.mem_req_o}, 32'd1);
        bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0;
        chk("abort rd_wait req", {31'b0, bus.mem_req_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort ready",      {31'b0, bus.req_ready_o},  32'd1);
        chk("abort mem_req",    {31'b0, bus.mem_req_o},    32'd0);
        chk("abort mem_addr",   bus.mem_addr_o,            32'd0);
        chk("abort resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h00001234;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        chk("late rvalid resp", {31'b0, bus.resp_valid_o}, 32'd0);
        chk("late rvalid ready", {31'b0, bus.req_ready_o}, 32'd1);
        chk("late rvalid req", {31'b0, bus.mem_req_o}, 32'd0);
        $display("txn reset abort in RD_WAIT checked");
        do_op("sc postrst", F_SC, 32'h200, 32'h0000DEAD, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'h1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
